// File: rtl/count_seq_ctrl_if.sv
// Button/direction inputs and display/status outputs of the count sequencer.
interface count_seq_ctrl_if;
    logic        btn_start;
    logic        btn_clear;
    logic        dir;
    logic [15:0] count_bcd;
    logic [3:0]  digit_val;
    logic [3:0]  digit_sel;
    logic        running;
    logic        wrap;

    modport master (
        output btn_start, btn_clear, dir,
        input  count_bcd, digit_val, digit_sel, running, wrap
    );

    modport slave (
        input  btn_start, btn_clear, dir,
        output count_bcd, digit_val, digit_sel, running, wrap
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Start/pause/clear sequencer for a 4-digit BCD event counter with a
// time-multiplexed single-decoder 7-segment scan.
module count_seq_ctrl #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SCAN_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    count_seq_ctrl_if.slave  bus_io
);

    localparam int unsigned PRE_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    state_e            state_q;
    logic              running_q;
    logic              start_prev_q;
    logic              clear_prev_q;
    logic [PRE_W-1:0]  presc_q;
    logic [15:0]       count_q;
    logic [15:0]       count_d;
    logic              wrap_q;
    logic              wrap_d;
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_d;
    logic [1:0]        scan_idx_q;
    logic [1:0]        scan_idx_d;
    logic [3:0]        digit_sel_q;
    logic [3:0]        digit_val_q;

    logic              start_edge;
    logic              clear_edge;
    logic              tick;
    logic [15:0]       inc_v;
    logic [15:0]       dec_v;
    logic              inc_wrap;
    logic              dec_wrap;
    logic              carry;
    logic              borrow;

    // Rising-edge detection on the debounced button levels.
    assign start_edge = bus_io.btn_start & ~start_prev_q;
    assign clear_edge = bus_io.btn_clear & ~clear_prev_q;
    assign tick       = (state_q == ST_RUN) && (presc_q == PRE_MAX);

    // BCD increment/decrement candidates with ripple carry/borrow across nibbles.
    always_comb begin
        inc_v  = count_q;
        dec_v  = count_q;
        carry  = 1'b1;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_v[4*i +: 4] = 4'd0;
                end else begin
                    inc_v[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_v[4*i +: 4] = 4'd9;
                end else begin
                    dec_v[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow          = 1'b0;
                end
            end
        end
        inc_wrap = carry;
        dec_wrap = borrow;
    end

    // Next count value: clear wins, otherwise step on a tick in the sampled direction.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear_edge) begin
            count_d = 16'h0000;
        end else if (tick) begin
            count_d = bus_io.dir ? dec_v : inc_v;
            wrap_d  = bus_io.dir ? dec_wrap : inc_wrap;
        end
    end

    // Free-running scan position, independent of the counter state.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
    end

    // Run/pause/idle sequencing, prescaler, counter and edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            running_q    <= 1'b0;
            start_prev_q <= 1'b1;
            clear_prev_q <= 1'b1;
            presc_q      <= '0;
            count_q      <= 16'h0000;
            wrap_q       <= 1'b0;
        end else begin
            start_prev_q <= bus_io.btn_start;
            clear_prev_q <= bus_io.btn_clear;
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            if (clear_edge) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
                presc_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        presc_q <= '0;
                        if (start_edge) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        presc_q <= tick ? '0 : presc_q + PRE_W'(1);
                        if (start_edge) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_edge) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                        presc_q   <= '0;
                    end
                endcase
            end
        end
    end

    // Display scan registers; select and value load together from the next index/count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q  <= '0;
            scan_idx_q  <= 2'd0;
            digit_sel_q <= 4'b1110;
            digit_val_q <= 4'h0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
            digit_sel_q <= ~(4'b0001 << scan_idx_d);
            digit_val_q <= count_d[{scan_idx_d, 2'b00} +: 4];
        end
    end

    assign bus_io.count_bcd = count_q;
    assign bus_io.digit_val = digit_val_q;
    assign bus_io.digit_sel = digit_sel_q;
    assign bus_io.running   = running_q;
    assign bus_io.wrap      = wrap_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Scoreboard bench for count_seq_ctrl: an integer-level model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_count_seq_ctrl;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned SCAN_DIV = 2;

    typedef struct packed {
        logic [15:0] cnt;
        logic [3:0]  dv;
        logic [3:0]  ds;
        logic        run;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    count_seq_ctrl_if bus_if ();

    count_seq_ctrl #(.CLK_DIV(CLK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus_if)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    // Reference model: mode 0=idle 1=run 2=pause, count held as a plain integer.
    int m_mode, m_cnt, m_presc, m_sc, m_idx;
    bit m_pbs, m_pbc, m_wrap;

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r;
        int v;
        v = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic exp_t expv();
        exp_t e;
        int v;
        logic [3:0] one;
        one = 4'b0001;
        v = m_cnt;
        for (int k = 0; k < m_idx; k++) v = v / 10;
        e.cnt  = to_bcd(m_cnt);
        e.dv   = 4'(v % 10);
        e.ds   = ~(one << m_idx);
        e.run  = (m_mode == 1);
        e.wrap = m_wrap;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_presc = 0; m_sc = 0; m_idx = 0;
        m_pbs = 1'b1; m_pbc = 1'b1; m_wrap = 1'b0;
    endtask

    task automatic model_step(bit bs, bit bc, bit d);
        bit se, ce;
        se = bs && !m_pbs;
        ce = bc && !m_pbc;
        m_pbs = bs;
        m_pbc = bc;
        m_wrap = 1'b0;
        if (ce) begin
            m_mode = 0; m_cnt = 0; m_presc = 0;
        end else if (m_mode == 0) begin
            m_presc = 0;
            if (se) m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_presc == int'(CLK_DIV) - 1) begin
                m_presc = 0;
                if (!d) begin
                    m_cnt  = (m_cnt + 1) % 10000;
                    m_wrap = (m_cnt == 0);
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + 9999) % 10000;
                end
            end else begin
                m_presc = m_presc + 1;
            end
            if (se) m_mode = 2;
        end else begin
            if (se) m_mode = 1;
        end
        if (m_sc == int'(SCAN_DIV) - 1) begin
            m_sc  = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_sc = m_sc + 1;
        end
    endtask

    task automatic compare(exp_t e);
        checks += 5;
        if (bus_if.count_bcd !== e.cnt) begin
            failures++;
            $display("FAIL count_bcd t=%0t got=%h exp=%h", $time, bus_if.count_bcd, e.cnt);
        end
        if (bus_if.digit_val !== e.dv) begin
            failures++;
            $display("FAIL digit_val t=%0t got=%h exp=%h", $time, bus_if.digit_val, e.dv);
        end
        if (bus_if.digit_sel !== e.ds) begin
            failures++;
            $display("FAIL digit_sel t=%0t got=%b exp=%b", $time, bus_if.digit_sel, e.ds);
        end
        if (bus_if.running !== e.run) begin
            failures++;
            $display("FAIL running t=%0t got=%b exp=%b", $time, bus_if.running, e.run);
        end
        if (bus_if.wrap !== e.wrap) begin
            failures++;
            $display("FAIL wrap t=%0t got=%b exp=%b", $time, bus_if.wrap, e.wrap);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic cycle(bit bs, bit bc, bit d);
        bus_if.btn_start = bs;
        bus_if.btn_clear = bc;
        bus_if.dir       = d;
        @(posedge clk);
        model_step(bs, bc, d);
        q.push_back(expv());
        #1;
    endtask

    // Asynchronous reset away from the clock edge, checked immediately and across one edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        compare(expv());
        @(posedge clk);
        q.push_back(expv());
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every output sample is checked against the oldest prediction.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) compare(q.pop_front());
        end
    end

    initial begin
        bit bs, bc, d;
        reset            = 1'b1;
        bus_if.btn_start = 1'b1;
        bus_if.btn_clear = 1'b0;
        bus_if.dir       = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Start held high through reset: no run until a fresh rising edge.
        do_reset();
        repeat (6) cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (40) cycle(1, 0, 0);

        // Pause with the prescaler part-way, hold, resume.
        for (int n = 0; n < 10 && m_presc != 2; n++) cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (20) cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (12) cycle(0, 0, 0);

        // Clear, then wrap down from 0000 and back up from 9999.
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 1);
        repeat (9) cycle(0, 0, 1);
        repeat (10) cycle(0, 0, 0);

        // Simultaneous start and clear while running.
        repeat (7) cycle(0, 0, 0);
        cycle(1, 1, 0);
        repeat (4) cycle(0, 0, 0);

        // Randomized button activity and direction changes.
        bs = 1'b0; bc = 1'b0; d = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) bs = ~bs;
            bc = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 49) == 0) d = ~d;
            cycle(bs, bc, d);
        end

        // Reset asserted in the middle of a run.
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (13) cycle(1, 0, 0);
        do_reset();
        repeat (5) cycle(0, 0, 0);

        // Count up to 4321, pause, and observe the display scan.
        cycle(1, 0, 0);
        for (int n = 0; n < 20000 && m_cnt != 4321; n++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        repeat (24) cycle(1, 0, 0);

        for (int n = 0; n < 5 && q.size() > 0; n++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
